relu_vec_pipe: RTL and testbench
================================

// Module: relu_vec_pipe
// PURPOSE
//  Parametrised multi-lane activation unit; successor to the single-word ReLU stage.
//  Applies a per-beat selectable activation (bypass / ReLU / clipped ReLU / leaky ReLU) to LANES signed words.
//  Sits between the PE-array accumulator output and the output buffer.
//  Two-stage pipeline with valid/ready backpressure; keeps a saturating count of lanes zeroed or clipped.
// PARAMETERS
//  WORD_SIZE    16  bits per lane, signed two's complement
//  LANES        4   lanes per beat
//  LEAKY_SHIFT  3   arithmetic right-shift applied to negative inputs in leaky mode
//  CNT_W        16  width of the event counter
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous reset, active-low
//  di_valid   in   1                  input beat valid
//  di_ready   out  1                  unit can accept a beat this cycle
//  di         in   LANES*WORD_SIZE    input lanes; lane i = di[i*WORD_SIZE +: WORD_SIZE]
//  di_mode    in   2                  0 bypass, 1 ReLU, 2 clipped ReLU, 3 leaky ReLU; sampled with the beat
//  clip_val   in   WORD_SIZE          signed upper bound for mode 2; sampled with the beat
//  do_valid   out  1                  output beat valid
//  do_ready   in   1                  downstream accepts the beat
//  do_data    out  LANES*WORD_SIZE    activated lanes, same packing as di
//  evt_cnt    out  CNT_W              saturating count of lanes modified by mode 1/2/3
//  evt_clr    in   1                  synchronous clear of evt_cnt
// BEHAVIOUR
//  Reset (rst=0, async): s1/s2 valid=0; do_valid=0; do_data=0; evt_cnt=0. di_ready is 1 one cycle after release.
//  Handshake: beat transfers at input when di_valid&di_ready; at output when do_valid&do_ready.
//   - do_valid/do_data hold stable while do_valid & !do_ready; no beat is dropped or duplicated.
//  Pipeline: S1 registers di, di_mode, clip_val; S2 registers the computed result.
//   - S2 loads when !s2_valid | do_ready; S1 advances when S2 loads.
//   - di_ready = !s1_valid | s2_load (combinational, no comb path from di_valid).
//   - Latency: a beat accepted in cycle N is presented in cycle N+2 with do_ready held high.
//   - Throughput: 1 beat/cycle with do_ready high; under stall, 2 beats buffered, then di_ready=0.
//  Per-lane function, x signed:
//   - mode 0: y=x.
//   - mode 1: y = x<0 ? 0 : x.
//   - mode 2: y = x<0 ? 0 : (x>clip_val ? clip_val : x); clip_val<0 is treated as 0 (y=0 for all x).
//   - mode 3: y = x<0 ? (x >>> LEAKY_SHIFT) : x; result truncates toward -inf (-1 -> -1, -9 -> -2 at shift 3).
//   - No widening; output width = WORD_SIZE; most-negative input is valid in every mode.
//  evt_cnt: on each S1->S2 transfer, add the number of lanes whose y != x (mode 0 adds 0).
//   - Saturates at 2^CNT_W-1; never wraps.
//   - evt_clr has priority over a same-cycle increment: the result is 0, and that beat's count is lost.
//  Mode/clip changes between beats take effect per beat; in-flight beats keep their sampled mode.
//  Reset mid-operation flushes both stages; the beats in flight are discarded and not replayed.
// TESTING  (WORD_SIZE=16, LANES=4, LEAKY_SHIFT=3)
//  1 mode1, di={-5,0,7,-32768}, do_ready=1 -> do_data={0,0,7,0} 2 cycles later; evt_cnt +=2.
//  2 mode2, clip_val=6, di={-1,6,7,100} -> {0,6,6,6}, evt_cnt +=3; repeat with clip_val=-4 -> {0,0,0,0}.
//  3 mode3, di={-1,-9,-8,5} -> {-1,-2,-1,5}; mode0, di={-3,3,0,-32768} -> unchanged, evt_cnt +=0.
//  4 stream 10 beats, do_ready low for cycles 3-7 -> di_ready drops after 2 buffered beats; output order and data match input; no loss.
//  5 preload evt_cnt to 0xFFFE, send mode1 beat with 4 negatives -> evt_cnt=0xFFFF; assert evt_clr with a beat -> evt_cnt=0.
//  6 assert rst with 2 beats in flight -> do_valid=0, evt_cnt=0 immediately; after release, first new beat appears at latency 2.

Source files
------------

// File: rtl/relu_vec_pipe_if.sv
// -----------------------------------------------------------------------------
// relu_vec_pipe_if
//   Bundles the beat handshake, the lane data, the per-beat activation controls
//   and the event-counter signals of relu_vec_pipe.
//
//   master : the environment side (drives input beats, accepts output beats,
//            clears the counter)
//   slave  : the activation unit itself
//
//   di_valid / di_ready  input beat handshake
//   di                   LANES signed words, lane i = di[i*WORD_SIZE +: WORD_SIZE]
//   di_mode              0 bypass, 1 ReLU, 2 clipped ReLU, 3 leaky ReLU
//   clip_val             signed upper bound for clipped ReLU
//   do_valid / do_ready  output beat handshake
//   do_data              activated lanes, same packing as di
//   evt_cnt              saturating count of lanes changed by the activation
//   evt_clr              synchronous clear of evt_cnt
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface relu_vec_pipe_if #(
  parameter int WORD_SIZE = 16,
  parameter int LANES     = 4,
  parameter int CNT_W     = 16
);
  logic                          di_valid;
  logic                          di_ready;
  logic [LANES*WORD_SIZE-1:0]    di;
  logic [1:0]                    di_mode;
  logic signed [WORD_SIZE-1:0]   clip_val;
  logic                          do_valid;
  logic                          do_ready;
  logic [LANES*WORD_SIZE-1:0]    do_data;
  logic [CNT_W-1:0]              evt_cnt;
  logic                          evt_clr;

  modport master (
    output di_valid, di, di_mode, clip_val, do_ready, evt_clr,
    input  di_ready, do_valid, do_data, evt_cnt
  );

  modport slave (
    input  di_valid, di, di_mode, clip_val, do_ready, evt_clr,
    output di_ready, do_valid, do_data, evt_cnt
  );
endinterface

// File: rtl/relu_vec_pipe.sv
// -----------------------------------------------------------------------------
// relu_vec_pipe
//   Multi-lane activation unit placed between the PE-array accumulator output
//   and the output buffer. Each beat carries LANES signed words plus its own
//   activation mode and clip bound; the result leaves two cycles later through
//   a valid/ready output with full backpressure. A saturating counter tallies
//   how many lanes the activation actually changed.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active-low
//     bus  : relu_vec_pipe_if.slave (handshakes, lane data, mode, clip,
//            event counter and its clear)
//
//   Pipeline
//     p1 : input beat register (lanes, mode, clip); the activation is computed
//          combinationally from these registers
//     p2 : result register that drives do_data / do_valid
//   p2 loads whenever it is empty or being drained; p1 advances with p2, so
//   two beats can be held while the output is stalled.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module relu_vec_pipe #(
  parameter int WORD_SIZE   = 16,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  relu_vec_pipe_if.slave bus
);

  localparam int VEC_W = LANES * WORD_SIZE;
  // Wide enough to hold the number of changed lanes in one beat (0..LANES).
  localparam int INC_W = $clog2(LANES + 1);

  // ---------------------------------------------------------------------------
  // Per-lane activation. A negative clip bound behaves as zero, so clipped
  // ReLU then forces every lane to zero. The leaky path uses an arithmetic
  // shift, which rounds toward minus infinity and never overflows, so the
  // most-negative input needs no special case.
  // ---------------------------------------------------------------------------
  function automatic logic signed [WORD_SIZE-1:0] act_lane(
    input logic signed [WORD_SIZE-1:0] x,
    input logic [1:0]                  mode,
    input logic signed [WORD_SIZE-1:0] clip
  );
    logic signed [WORD_SIZE-1:0] c;
    logic signed [WORD_SIZE-1:0] y;
    c = clip[WORD_SIZE-1] ? '0 : clip;
    y = x;
    case (mode)
      2'd0: y = x;
      2'd1: y = x[WORD_SIZE-1] ? '0 : x;
      2'd2: begin
        if (x[WORD_SIZE-1])
          y = '0;
        else if (x > c)
          y = c;
        else
          y = x;
      end
      default: y = x[WORD_SIZE-1] ? (x >>> LEAKY_SHIFT) : x;
    endcase
    return y;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [INC_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W + 1 - INC_W){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Control and datapath state
  // ---------------------------------------------------------------------------
  logic                        run_p0;   // set one cycle after reset release
  logic                        vld_p1;
  logic [VEC_W-1:0]            x_p1;
  logic [1:0]                  mode_p1;
  logic signed [WORD_SIZE-1:0] clip_p1;

  logic                        vld_p2;
  logic [VEC_W-1:0]            data_p2;

  logic [CNT_W-1:0]            cnt;

  logic                        s1_load;
  logic                        s2_load;
  logic [VEC_W-1:0]            y_p1;
  logic [INC_W-1:0]            inc_p1;
  logic signed [WORD_SIZE-1:0] lane_x;
  logic signed [WORD_SIZE-1:0] lane_y;

  // p2 can take a new value when it is empty or its current beat is leaving;
  // p1 frees up exactly when p2 takes its beat. Neither term looks at
  // di_valid, so there is no combinational path from di_valid to di_ready.
  assign s2_load = !vld_p2 || bus.do_ready;
  assign s1_load = run_p0 && (!vld_p1 || s2_load);

  assign bus.di_ready = s1_load;
  assign bus.do_valid = vld_p2;
  assign bus.do_data  = data_p2;
  assign bus.evt_cnt  = cnt;

  // ---------------------------------------------------------------------------
  // Stage 0 -> 1 : input beat capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      run_p0 <= 1'b1;
      if (s1_load)
        vld_p1 <= bus.di_valid;
    end
  end

  // Lane data, mode and clip travel with the beat; they need no reset because
  // vld_p1 qualifies them.
  always_ff @(posedge clk) begin
    if (s1_load && bus.di_valid) begin
      x_p1    <= bus.di;
      mode_p1 <= bus.di_mode;
      clip_p1 <= bus.clip_val;
    end
  end

  // Activation of the beat held in p1, plus the count of lanes it changed.
  always_comb begin
    y_p1   = '0;
    inc_p1 = '0;
    lane_x = '0;
    lane_y = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_x = x_p1[i*WORD_SIZE +: WORD_SIZE];
      lane_y = act_lane(lane_x, mode_p1, clip_p1);
      y_p1[i*WORD_SIZE +: WORD_SIZE] = lane_y;
      if (lane_y != lane_x)
        inc_p1 = inc_p1 + INC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 -> 2 : result register and event counter
  // ---------------------------------------------------------------------------
  // do_data is cleared by reset so the output bus reads zero until the first
  // beat arrives; it only changes when a valid beat moves in, so it holds
  // steady throughout a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (s2_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1)
        data_p2 <= y_p1;
    end
  end

  // A clear wins over a same-cycle increment; that beat's count is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (bus.evt_clr)
      cnt <= '0;
    else if (s2_load && vld_p1)
      cnt <= sat_add(cnt, inc_p1);
  end

endmodule

// File: tb/tb_relu_vec_pipe.sv
`timescale 1ns/1ps

module tb_relu_vec_pipe;
  localparam int W  = 16;
  localparam int L  = 4;
  localparam int LS = 3;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  relu_vec_pipe_if #(.WORD_SIZE(W), .LANES(L), .CNT_W(CW)) bus ();

  relu_vec_pipe #(.WORD_SIZE(W), .LANES(L), .LEAKY_SHIFT(LS), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [L*W-1:0] exp_q[$];
  int             exp_cnt = 0;
  int             in_cnt  = 0;
  int             out_cnt = 0;
  logic           stall_prev = 1'b0;
  logic [L*W-1:0] data_prev  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference activation on plain integers.
  function automatic int model_lane(input int x, input int mode, input int clip);
    int c;
    int q;
    c = (clip < 0) ? 0 : clip;
    case (mode)
      0: return x;
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? 0 : ((x > c) ? c : x);
      default: begin
        if (x >= 0) return x;
        q = x / (1 << LS);              // truncates toward zero
        if (q * (1 << LS) != x) q = q - 1;  // floor for negatives
        return q;
      end
    endcase
  endfunction

  task automatic model_beat(input logic [L*W-1:0] d, input int mode, input int clip,
                            output logic [L*W-1:0] y, output int n);
    int x;
    int r;
    y = '0;
    n = 0;
    for (int i = 0; i < L; i++) begin
      x = int'($signed(d[i*W +: W]));
      r = model_lane(x, mode, clip);
      y[i*W +: W] = r[W-1:0];
      if (r != x) n++;
    end
  endtask

  function automatic logic [L*W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {a3[W-1:0], a2[W-1:0], a1[W-1:0], a0[W-1:0]};
  endfunction

  function automatic int rand_lane();
    case ($urandom_range(0, 4))
      0: return -32768;
      1: return 32767;
      2: return 0;
      3: return -1;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  function automatic int rand_clip();
    case ($urandom_range(0, 3))
      0: return -4;
      1: return 0;
      2: return 100;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  // Scoreboard: capture accepted beats, compare every delivered beat, and
  // verify the output holds while stalled. Sampled on the falling edge.
  always @(negedge clk) begin
    logic [L*W-1:0] y;
    int             n;
    if (rst) begin
      if (stall_prev) begin
        check("hold_valid", bus.do_valid, 1);
        check("hold_data", bus.do_data, data_prev);
      end
      if (bus.do_valid && bus.do_ready) begin
        if (exp_q.size() == 0)
          check("out_unexpected_beat", exp_q.size(), 1);
        else
          check("out_data", bus.do_data, exp_q.pop_front());
        out_cnt++;
      end
      if (bus.di_valid && bus.di_ready) begin
        model_beat(bus.di, int'(bus.di_mode), int'($signed(bus.clip_val)), y, n);
        exp_q.push_back(y);
        exp_cnt = (exp_cnt + n > CNT_MAX) ? CNT_MAX : exp_cnt + n;
        in_cnt++;
      end
      stall_prev = bus.do_valid && !bus.do_ready;
      data_prev  = bus.do_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input int mode, input int clip, input logic [L*W-1:0] d);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    bus.di       = d;
    bus.di_mode  = mode[1:0];
    bus.clip_val = clip[W-1:0];
    bus.di_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.di_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.di_valid = 1'b0;
    check("send_accepted", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.di_valid = 1'b0;
    bus.do_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.do_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", (exp_q.size() == 0) && !bus.do_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L*W-1:0] sd[10];
    int             sm[10];
    int             sc[10];
    int             b;
    int             c;
    bit             acc;

    rst          = 1'b0;
    bus.di_valid = 1'b0;
    bus.di       = '0;
    bus.di_mode  = 2'd0;
    bus.clip_val = '0;
    bus.do_ready = 1'b1;
    bus.evt_clr  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_do_valid", bus.do_valid, 0);
    check("rst_do_data", bus.do_data, 0);
    check("rst_evt_cnt", bus.evt_cnt, 0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_release", bus.di_ready, 1);

    // ReLU with latency check
    send(1, 0, pack(-5, 0, 7, -32768));
    check("t1_lat_n1_valid", bus.do_valid, 0);
    @(posedge clk);
    #1;
    check("t1_lat_n2_valid", bus.do_valid, 1);
    check("t1_data", bus.do_data, pack(0, 0, 7, 0));
    drain();
    check("t1_cnt", bus.evt_cnt, 2);

    // Clipped ReLU, positive then negative bound
    send(2, 6, pack(-1, 6, 7, 100));
    drain();
    check("t2_data", bus.do_data, pack(0, 6, 6, 6));
    check("t2_cnt", bus.evt_cnt, 5);
    send(2, -4, pack(-1, 6, 7, 100));
    drain();
    check("t2_negclip_data", bus.do_data, pack(0, 0, 0, 0));
    check("t2_negclip_cnt", bus.evt_cnt, 9);

    // Leaky ReLU and bypass
    send(3, 0, pack(-1, -9, -8, 5));
    drain();
    check("t3_leaky_data", bus.do_data, pack(-1, -2, -1, 5));
    check("t3_leaky_cnt", bus.evt_cnt, 11);
    send(3, 0, pack(-32768, 0, -7, 32767));
    drain();
    check("t3_leaky_minneg", bus.do_data, pack(-4096, 0, -1, 32767));
    send(0, 0, pack(-3, 3, 0, -32768));
    drain();
    check("t3_bypass_data", bus.do_data, pack(-3, 3, 0, -32768));
    check("t3_bypass_cnt", bus.evt_cnt, 13);

    // Stream of 10 beats with the output stalled in cycles 3..7
    for (int i = 0; i < 10; i++) begin
      sd[i] = pack(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      sm[i] = $urandom_range(0, 3);
      sc[i] = rand_clip();
    end
    b = 0;
    c = 0;
    while ((b < 10 || exp_q.size() != 0) && c < 100) begin
      bus.do_ready = !(c >= 3 && c <= 7);
      bus.di_valid = (b < 10);
      if (b < 10) begin
        bus.di       = sd[b];
        bus.di_mode  = sm[b][1:0];
        bus.clip_val = sc[b][W-1:0];
      end
      if (c == 7) begin
        check("t4_stall_ready", bus.di_ready, 0);
        check("t4_stall_buffered", in_cnt - out_cnt, 2);
      end
      @(negedge clk);
      acc = bus.di_valid && bus.di_ready;
      @(posedge clk);
      #1;
      if (acc) b++;
      c++;
    end
    check("t4_all_sent", b, 10);
    drain();
    check("t4_in_eq_out", in_cnt, out_cnt);
    check("t4_cnt", bus.evt_cnt, exp_cnt);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      bus.di_valid = ($urandom_range(0, 3) != 0);
      bus.do_ready = ($urandom_range(0, 3) != 0);
      bus.di       = pack(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      bus.di_mode  = 2'($urandom_range(0, 3));
      bus.clip_val = 16'(rand_clip());
      @(posedge clk);
      #1;
    end
    drain();
    check("rand_in_eq_out", in_cnt, out_cnt);
    check("rand_cnt", bus.evt_cnt, exp_cnt);

    // Reset with two beats in flight
    bus.do_ready = 1'b0;
    send(1, 0, pack(-1, -2, -3, -4));
    send(1, 0, pack(-5, -6, -7, -8));
    #2 rst = 1'b0;
    #1;
    check("t6_rst_do_valid", bus.do_valid, 0);
    check("t6_rst_evt_cnt", bus.evt_cnt, 0);
    check("t6_rst_do_data", bus.do_data, 0);
    exp_q.delete();
    exp_cnt = 0;
    in_cnt  = 0;
    out_cnt = 0;
    bus.do_ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rdy_after_release", bus.di_ready, 1);
    check("t6_no_replay", bus.do_valid, 0);
    send(1, 0, pack(1, -2, 3, -4));
    check("t6_lat_n1_valid", bus.do_valid, 0);
    @(posedge clk);
    #1;
    check("t6_lat_n2_valid", bus.do_valid, 1);
    check("t6_data", bus.do_data, pack(1, 0, 3, 0));
    drain();
    check("t6_cnt", bus.evt_cnt, 2);

    // Counter saturation: bring it to 0xFFFE through real traffic
    bus.evt_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.evt_clr = 1'b0;
    exp_cnt = 0;
    check("t5_clr_idle", bus.evt_cnt, 0);
    for (int i = 0; i < 16383; i++)
      send(1, 0, pack(-1 - $urandom_range(0, 32767), -1 - $urandom_range(0, 32767),
                      -1 - $urandom_range(0, 32767), -1 - $urandom_range(0, 32767)));
    send(1, 0, pack(-1, -1, 0, 0));
    drain();
    check("t5_preload", bus.evt_cnt, 16'hFFFE);
    send(1, 0, pack(-10, -20, -30, -40));
    drain();
    check("t5_saturate", bus.evt_cnt, 16'hFFFF);
    check("t5_model_cnt", bus.evt_cnt, exp_cnt);
    send(1, 0, pack(-10, -20, -30, -40));
    drain();
    check("t5_no_wrap", bus.evt_cnt, 16'hFFFF);

    // Clear in the same cycle the beat moves into the result stage
    send(1, 0, pack(-1, -2, -3, -4));
    bus.evt_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.evt_clr = 1'b0;
    exp_cnt = 0;
    check("t5_clr_priority", bus.evt_cnt, 0);
    drain();
    check("t5_clr_beat_lost", bus.evt_cnt, 0);
    check("t5_clr_data", bus.do_data, pack(0, 0, 0, 0));
    check("final_in_eq_out", in_cnt, out_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
